dff_serial_tx: RTL
==================

Name: dff_serial_tx

Overview:
- Launch-side counterpart to the team's capture flip-flop: converts a parallel word into a single-bit serial stream, one bit per rising clk edge.
- The stream is sampled by a downstream D flip-flop or shift register.
- Optional framing (start/stop bits) lets the capture side find word boundaries.
- Sits between a parallel producer (valid/ready style load) and a single-wire serial link.

Parameters:
- WIDTH, 8, data word width in bits (2..32).
- MSB_FIRST, 1, 1 = transmit bit WIDTH-1 first; 0 = bit 0 first.
- FRAMED, 1, 1 = prefix start bit (0) and append stop bit (1); 0 = raw data bits only.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  reset, synchronous and active-high.
- din  input  WIDTH  parallel word; sampled only on an accepted load.
- load  input  1  producer valid; accepted on a rising edge where load=1 and ready=1.
- ready  output  1  block can accept a word (registered).
- sout  output  1  serial data out, registered; idle level 1.
- busy  output  1  a word is in flight (registered).
- done  output  1  one-cycle pulse when the last bit period of a word has ended.

Behaviour:
- Clock and reset: one clock, clk. rst is synchronous and active-high.
- All outputs are registered. There is no combinational path from inputs to outputs.
- Reset values (at the first edge with rst=1): state=IDLE, sout=1, ready=1, busy=0, done=0, bit counter=0, shift register=0.
- States:
  - IDLE: sout=1, ready=1, busy=0.
  - START (FRAMED=1 only): sout=0 for 1 cycle.
  - DATA: WIDTH cycles, one data bit per cycle.
  - STOP (FRAMED=1 only): sout=1 for 1 cycle.
- Transitions:
  - IDLE->START on accept when FRAMED=1; IDLE->DATA on accept when FRAMED=0.
  - START->DATA after 1 cycle.
  - DATA->STOP after WIDTH bits when FRAMED=1; DATA->IDLE when FRAMED=0.
  - STOP->IDLE after 1 cycle.
- Accept: at edge k with load=1 and ready=1, din is captured into the shift register. ready=0 and busy=1 from k+1.
- Timing with FRAMED=1:
  - sout=start bit in cycle k+1.
  - Data bits in cycles k+2 .. k+WIDTH+1.
  - Stop bit in cycle k+WIDTH+2.
  - At edge k+WIDTH+3: return to IDLE, ready=1, busy=0, done=1 for exactly that cycle.
- Timing with FRAMED=0: data bits in cycles k+1 .. k+WIDTH; done, ready=1 and busy=0 at edge k+WIDTH+1.
- Bit order: MSB_FIRST=1 shifts left and drives sr[WIDTH-1]; MSB_FIRST=0 shifts right and drives sr[0].
- Bit counter: width clog2(WIDTH)+1, counts 0..WIDTH-1 in DATA, cleared on leaving DATA. No wrap inside a word.
- Back-to-back: load=1 in the cycle where done=1 (ready=1) is accepted at that edge. The next start bit follows immediately, with no idle gap beyond the done cycle.
- load=1 while ready=0 is ignored: not queued, no effect on the word in flight. din changes while busy have no effect.
- Reset mid-operation: rst=1 in any state aborts the word. sout=1, state=IDLE, ready=1 at that edge. done is NOT pulsed for the aborted word.
- rst and load asserted together: rst wins; the word is not accepted.
- While idle, sout is held at 1 and done stays 0.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, release, hold load=0 for 10 cycles -> sout=1, ready=1, busy=0, done=0 throughout.
- MSB-first framed (WIDTH=8, MSB_FIRST=1, FRAMED=1): load 0xA5 at edge k -> sout over cycles k+1..k+10 = 0,1,0,1,0,0,1,0,1,1. done=1 only at k+11; ready=1 at k+11.
- LSB-first framed (MSB_FIRST=0): load 0x01 -> sout = 0,1,0,0,0,0,0,0,0,1. A capture DFF shift register sampling the 8 data cycles reconstructs 0x01.
- Back-to-back and ignored load: load 0x00, then hold load=1 continuously with din=0xFF from the first edge after the accept.
  - During the first word: ready=0; din=0xFF is not captured until the done cycle.
  - Second word then follows: sout = 0,1,1,1,1,1,1,1,1,1.
  - The two frames are separated only by the done cycle, not by extra idle cycles.
- Reset mid-frame: load 0xF0, assert rst for 1 cycle during the 3rd data bit -> sout=1, ready=1, busy=0 at the next edge. No done pulse. A fresh load of 0x3C then transmits a correct full frame.
- Unframed (FRAMED=0, WIDTH=4, MSB_FIRST=1): load 0xA at edge k -> sout over k+1..k+4 = 1,0,1,0. done=1 at k+5.

Source files
------------

// File: rtl/dff_serial_tx.sv
// Parallel-to-serial launch register with optional start/stop framing.
// One bit per clk edge; every output comes straight from a flop.
module dff_serial_tx #(
   parameter int WIDTH     = 8,
   parameter bit MSB_FIRST = 1'b1,
   parameter bit FRAMED    = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] din,
   input  logic             load,
   output logic             ready,
   output logic             sout,
   output logic             busy,
   output logic             done
);

   localparam int CW = $clog2(WIDTH) + 1;

   typedef enum logic [1:0] {
      IDLE,
      START,
      DATA,
      STOP
   } state_t;

   state_t           state, state_n;
   logic [WIDTH-1:0] sr, sr_n;
   logic [WIDTH-1:0] word, word_sh;
   logic [CW-1:0]    cnt, cnt_n;
   logic             sout_n, ready_n, busy_n, done_n;
   logic             bit_out, last;

   // Unframed words launch their first bit straight from din.
   always_comb begin
      word    = (state == IDLE) ? din : sr;
      bit_out = MSB_FIRST ? word[WIDTH-1] : word[0];
      word_sh = MSB_FIRST ? {word[WIDTH-2:0], 1'b0}
                          : {1'b0, word[WIDTH-1:1]};
      last    = (cnt == CW'(WIDTH - 1));
   end

   always_comb begin
      state_n = state;
      sr_n    = sr;
      cnt_n   = cnt;
      sout_n  = sout;
      ready_n = ready;
      busy_n  = busy;
      done_n  = 1'b0;
      case (state)
         IDLE: begin
            sout_n  = 1'b1;
            ready_n = 1'b1;
            busy_n  = 1'b0;
            if (load && ready) begin
               ready_n = 1'b0;
               busy_n  = 1'b1;
               if (FRAMED) begin
                  state_n = START;
                  sr_n    = din;
                  sout_n  = 1'b0;
               end else begin
                  state_n = DATA;
                  sr_n    = word_sh;
                  sout_n  = bit_out;
                  cnt_n   = '0;
               end
            end
         end
         START: begin
            state_n = DATA;
            sr_n    = word_sh;
            sout_n  = bit_out;
            cnt_n   = '0;
         end
         DATA: begin
            if (last) begin
               cnt_n  = '0;
               sout_n = 1'b1;
               if (FRAMED) begin
                  state_n = STOP;
               end else begin
                  state_n = IDLE;
                  ready_n = 1'b1;
                  busy_n  = 1'b0;
                  done_n  = 1'b1;
               end
            end else begin
               cnt_n  = cnt + 1'b1;
               sr_n   = word_sh;
               sout_n = bit_out;
            end
         end
         STOP: begin
            state_n = IDLE;
            sout_n  = 1'b1;
            ready_n = 1'b1;
            busy_n  = 1'b0;
            done_n  = 1'b1;
         end
         default: begin
            state_n = IDLE;
            sout_n  = 1'b1;
            ready_n = 1'b1;
            busy_n  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         sr    <= '0;
         cnt   <= '0;
         sout  <= 1'b1;
         ready <= 1'b1;
         busy  <= 1'b0;
         done  <= 1'b0;
      end else begin
         state <= state_n;
         sr    <= sr_n;
         cnt   <= cnt_n;
         sout  <= sout_n;
         ready <= ready_n;
         busy  <= busy_n;
         done  <= done_n;
      end
   end

endmodule
